key_search_ctrl: RTL and testbench

Brute-force key sequencer for the RC4 cracking datapath. It sits directly downstream of the decrypted-byte checker. It consumes the checker's byte_valid / new_key verdict pulses, drives secret_key and restart/resume handshakes to the RC4 decrypt core, and tracks the message byte index. It reports found with the winning key, or failed on key-space exhaustion.

---
 rtl/rc4_pkg.sv | 21 ++
 rtl/key_counter.sv | 29 ++
 rtl/key_search_ctrl.sv | 129 ++++++++++++
 tb/tb_key_search_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared state encoding, default key/message sizes and the verdict timeout limit
package rc4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_KEY,
        WAIT_BYTE,
        CHECK,
        WAIT_VERDICT,
        NEXT_BYTE,
        NEXT_KEY,
        FOUND,
        FAIL
    } state_t;

    localparam int          DEF_KEY_WIDTH = 24;
    localparam logic [23:0] DEF_KEY_MAX   = 24'h3FFFFF;
    localparam int          DEF_MSG_LEN   = 32;
    localparam logic [3:0]  TIMEOUT_LIMIT = 4'd15;

endpackage

// File: rtl/key_counter.sv
// key_counter: loadable key incrementer with a last-key compare flag
module key_counter
    import rc4_pkg::*;
#(
    parameter int                   KEY_WIDTH = DEF_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(DEF_KEY_MAX)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 inc,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 at_max
);

    // load restarts the sweep; inc is only requested below KEY_MAX so the key never wraps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            key <= KEY_START;
        else if (load)
            key <= KEY_START;
        else if (inc)
            key <= key + 1'b1;
    end

    assign at_max = key == KEY_MAX;

endmodule

// File: rtl/key_search_ctrl.sv
// key_search_ctrl: brute-force RC4 key sequencer; optional verdict timeout under KEY_SEARCH_TIMEOUT_EN
module key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int                   KEY_WIDTH = DEF_KEY_WIDTH,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(DEF_KEY_MAX),
    parameter int                   MSG_LEN   = DEF_MSG_LEN,
    parameter int                   IDX_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 go,
    input  logic                 core_byte_ready,
    input  logic                 byte_valid,
    input  logic                 new_key,
    output logic                 core_restart,
    output logic                 byte_resume,
    output logic                 check_start,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic [IDX_WIDTH-1:0] byte_idx,
    output logic                 busy,
    output logic                 found,
    output logic                 failed
`ifdef KEY_SEARCH_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    state_t state;
    logic   idle_like;
    logic   last_byte;
    logic   at_max;
    logic   start;
    logic   timed_out;
    logic   reject;

    assign idle_like = state == IDLE || state == FOUND || state == FAIL;
    assign last_byte = byte_idx == IDX_WIDTH'(MSG_LEN - 1);
    assign start     = idle_like && go;
    assign reject    = state == WAIT_VERDICT && (new_key || timed_out);

    assign core_restart = state == LOAD_KEY;
    assign check_start  = state == CHECK;
    assign byte_resume  = state == NEXT_BYTE && !last_byte;
    assign busy         = !idle_like;

    key_counter #(
        .KEY_WIDTH(KEY_WIDTH),
        .KEY_START(KEY_START),
        .KEY_MAX  (KEY_MAX)
    ) u_key_counter (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (start),
        .inc    (state == NEXT_KEY && !at_max),
        .key    (secret_key),
        .at_max (at_max)
    );

`ifdef KEY_SEARCH_TIMEOUT_EN
    logic [3:0] wait_cnt;

    assign timed_out = !new_key && !byte_valid && wait_cnt == TIMEOUT_LIMIT - 4'd1;

    // count silent verdict cycles; the 15th silent cycle forces a reject and latches the error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= state == WAIT_VERDICT ? wait_cnt + 4'd1 : 4'd0;
            if (start)
                timeout_err <= 1'b0;
            else if (reject && timed_out)
                timeout_err <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // search sequencer: restart core per key, walk bytes until all pass or the key space runs out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            byte_idx <= '0;
            found    <= 1'b0;
            failed   <= 1'b0;
        end else begin
            case (state)
                IDLE, FOUND, FAIL:
                    if (go) begin
                        state    <= LOAD_KEY;
                        byte_idx <= '0;
                        found    <= 1'b0;
                        failed   <= 1'b0;
                    end
                LOAD_KEY:  state <= WAIT_BYTE;
                WAIT_BYTE: if (core_byte_ready) state <= CHECK;
                CHECK:     state <= WAIT_VERDICT;
                WAIT_VERDICT:
                    if (reject)
                        state <= NEXT_KEY;
                    else if (byte_valid)
                        state <= NEXT_BYTE;
                NEXT_BYTE:
                    if (last_byte) begin
                        found <= 1'b1;
                        state <= FOUND;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                        state    <= WAIT_BYTE;
                    end
                NEXT_KEY:
                    if (at_max) begin
                        failed <= 1'b1;
                        state  <= FAIL;
                    end else begin
                        byte_idx <= '0;
                        state    <= LOAD_KEY;
                    end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_search_ctrl.sv
// tb_key_search_ctrl: randomized core/checker environment with a per-key rejection plan model
module tb_key_search_ctrl;

    localparam int              KW   = 24;
    localparam int              IW   = 5;
    localparam int              ML   = 32;
    localparam int              NK   = 8;
    localparam logic [KW-1:0]   KMAX = 24'd7;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          go = 1'b0;
    logic          core_byte_ready = 1'b0;
    logic          byte_valid = 1'b0;
    logic          new_key = 1'b0;
    logic          core_restart, byte_resume, check_start, busy, found, failed;
    logic [KW-1:0] secret_key;
    logic [IW-1:0] byte_idx;
`ifdef KEY_SEARCH_TIMEOUT_EN
    logic          timeout_err;
`endif

    int checks = 0;
    int errors = 0;
    int rej[NK];
    bit force_both = 0;
    int silent_key = -1;
    int silent_idx = 0;

    always #5 clk = ~clk;

    key_search_ctrl #(
        .KEY_WIDTH(KW),
        .KEY_START('0),
        .KEY_MAX  (KMAX),
        .MSG_LEN  (ML),
        .IDX_WIDTH(IW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .go             (go),
        .core_byte_ready(core_byte_ready),
        .byte_valid     (byte_valid),
        .new_key        (new_key),
        .core_restart   (core_restart),
        .byte_resume    (byte_resume),
        .check_start    (check_start),
        .secret_key     (secret_key),
        .byte_idx       (byte_idx),
        .busy           (busy),
        .found          (found),
        .failed         (failed)
`ifdef KEY_SEARCH_TIMEOUT_EN
        ,
        .timeout_err    (timeout_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pulses/flags"}, {core_restart, byte_resume, check_start, busy, found, failed}, 6'b0);
        check({tag, " key"}, secret_key, 0);
        check({tag, " idx"}, byte_idx, 0);
    endtask

    // acts as RC4 core plus checker; abort_idx>=0 pulls reset while waiting for that byte of key 0
    task automatic run_search(input string tag, input int abort_idx);
        int  phase = 0;
        int  rdly = 0, vdly = 0, cycles = 0, verdict_cyc = 0, check_cyc = 0, last_kind = 0;
        int  restarts = 0, resumes = 0, cur_key = 0, cur_idx = 0;
        int  exp_rs = 0, exp_rm = 0, exp_key = 0, exp_idx = 0;
        bit  exp_found = 0, done = 0;
        for (int k = 0; k < NK; k++) begin
            exp_rs++;
            exp_key = k;
            if (rej[k] >= ML) begin
                exp_rm += ML - 1;
                exp_idx = ML - 1;
                exp_found = 1;
                break;
            end
            exp_rm += rej[k];
            exp_idx = rej[k];
        end
        go = 1'b1;
        while (!done && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            go = 1'b0;
            byte_valid = 1'b0;
            new_key = 1'b0;
            if (core_restart) begin
                restarts++;
                if (restarts == 1) check({tag, " go->restart"}, cycles, 1);
                else if (last_kind == 1) check({tag, " reject->restart"}, cycles - verdict_cyc, 2);
                else if (last_kind == 3) check({tag, " timeout->restart"}, cycles - check_cyc, 17);
                cur_key = restarts - 1;
                cur_idx = 0;
                phase = 1;
                rdly = $urandom_range(0, 2);
            end else if (byte_resume) begin
                resumes++;
                check({tag, " accept->resume"}, cycles - verdict_cyc, 1);
                cur_idx++;
                phase = 1;
                rdly = $urandom_range(0, 2);
            end else if (check_start) begin
                check({tag, " key@check"}, secret_key, cur_key);
                check({tag, " idx@check"}, byte_idx, cur_idx);
                core_byte_ready = 1'b0;
                phase = 2;
                vdly = $urandom_range(0, 3);
                check_cyc = cycles;
            end else if (phase == 2) begin
                if (vdly > 0) vdly--;
                else begin
                    phase = 0;
                    verdict_cyc = cycles;
                    if (cur_key == silent_key && cur_idx == silent_idx) last_kind = 3;
                    else if (cur_idx == rej[cur_key]) begin
                        new_key = 1'b1;
                        byte_valid = force_both | 1'($urandom_range(0, 1));
                        last_kind = 1;
                    end else begin
                        byte_valid = 1'b1;
                        last_kind = 2;
                    end
                end
            end
            if (phase == 1) begin
                if (abort_idx >= 0 && restarts == 1 && cur_idx == abort_idx) begin
                    reset_n = 1'b0;
                    core_byte_ready = 1'b0;
                    #1;
                    check_reset_outputs({tag, " async reset"});
                    return;
                end
                if (rdly > 0) begin
                    rdly--;
                    if ($urandom_range(0, 3) == 0) begin
                        byte_valid = 1'b1;
                        new_key = 1'($urandom_range(0, 1));
                    end
                end else core_byte_ready = 1'b1;
            end
            if (busy && $urandom_range(0, 7) == 0) go = 1'b1;
            if (!busy && cycles > 1) done = 1;
        end
        check({tag, " completed"}, done, 1);
        check({tag, " found"}, found, exp_found);
        check({tag, " failed"}, failed, !exp_found);
        check({tag, " key"}, secret_key, exp_key);
        check({tag, " idx"}, byte_idx, exp_idx);
        check({tag, " busy"}, busy, 0);
        check({tag, " restarts"}, restarts, exp_rs);
        check({tag, " resumes"}, resumes, exp_rm);
    endtask

    task automatic plan_all(input int v);
        for (int k = 0; k < NK; k++) rej[k] = v;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
`ifdef KEY_SEARCH_TIMEOUT_EN
        check("reset timeout_err", timeout_err, 0);
`endif
        reset_n = 1'b1;
        @(negedge clk);

        plan_all(ML);
        run_search("all_accept", -1);

        plan_all(ML);
        rej[0] = 5;
        run_search("reject_k0_b5", -1);

        for (int k = 0; k < NK; k++) rej[k] = $urandom_range(0, ML - 1);
        run_search("exhaust", -1);

        plan_all(ML);
        rej[0] = 0;
        force_both = 1;
        run_search("both_high", -1);
        force_both = 0;

        plan_all(ML);
        run_search("abort", 10);
        @(negedge clk);
        check_reset_outputs("held reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after release");

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NK; k++)
                rej[k] = ($urandom_range(0, 3) == 0) ? ML : $urandom_range(0, ML - 1);
            run_search($sformatf("random%0d", r), -1);
        end

`ifdef KEY_SEARCH_TIMEOUT_EN
        plan_all(ML);
        rej[0] = 3;
        silent_key = 0;
        silent_idx = 3;
        run_search("timeout", -1);
        check("timeout_err set", timeout_err, 1);
        silent_key = -1;
        plan_all(ML);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("timeout_err cleared by go", timeout_err, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
